// File: rtl/prefix_add_pkg.sv
// Shared definitions for the parallel-prefix adder stages.
// Carry recovery from group generate/propagate is shared by every stage that needs it.
package prefix_add_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int MAX_WIDTH     = 64;

  // Returns c[MAX_WIDTH:0]; callers keep only the low WIDTH+1 bits they use.
  function automatic logic [MAX_WIDTH:0] carry_from_prefix(
    input logic [MAX_WIDTH:1] G,
    input logic [MAX_WIDTH:1] P,
    input logic               cin
  );
    logic [MAX_WIDTH:0] c;
    c[0] = cin;
    for (int i = 1; i <= MAX_WIDTH; i++) begin
      c[i] = G[i] | (P[i] & cin);
    end
    return c;
  endfunction

endpackage

// File: rtl/prefix_sum_pipe_if.sv
// Handshake and data bundle between the prefix network, the sum pipe and its consumer.
// With PREFIX_SUM_OVF_EN defined the bundle also carries the signed-overflow flag.
interface prefix_sum_pipe_if #(
  parameter int WIDTH = prefix_add_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:1]   p_in;
  logic [WIDTH:1]   P_in;
  logic [WIDTH:1]   G_in;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:1]   sum;
  logic             cout;
`ifdef PREFIX_SUM_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, p_in, P_in, G_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, p_in, P_in, G_in, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, p_in, P_in, G_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, p_in, P_in, G_in, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/prefix_pipe_reg.sv
// One elastic pipeline slot: data register plus valid bit, loaded when adv is high.
// Data only loads on a valid beat so a bubble leaves the last result in place.
module prefix_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          valid_d,
  input  logic [DW-1:0] data_d,
  output logic          valid_q,
  output logic [DW-1:0] data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
      if (valid_d) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/prefix_sum_pipe.sv
// Final stage of a parallel-prefix add: two-slot elastic pipe producing sum/cout.
// Define PREFIX_SUM_OVF_EN to also register the two's-complement overflow flag.
module prefix_sum_pipe
  import prefix_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  prefix_sum_pipe_if.slave  bus
);

  localparam int S1_DW = 3 * WIDTH + 1;
`ifdef PREFIX_SUM_OVF_EN
  localparam int S2_DW = WIDTH + 2;
`else
  localparam int S2_DW = WIDTH + 1;
`endif

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;

  logic [S1_DW-1:0] s1_d;
  logic [S1_DW-1:0] s1_q;
  logic [WIDTH:1]   s1_p;
  logic [WIDTH:1]   s1_gp;
  logic [WIDTH:1]   s1_gg;
  logic             s1_cin;

  logic [MAX_WIDTH:1] gp_ext;
  logic [MAX_WIDTH:1] gg_ext;
  logic [MAX_WIDTH:0] c_full;
  logic [WIDTH:0]     c;
  logic [WIDTH:1]     sum_d;
  logic               c_unused;

  logic [S2_DW-1:0] s2_d;
  logic [S2_DW-1:0] s2_q;

  // Ready depends only on registered valids, never on in_valid.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign s1_d = {bus.p_in, bus.P_in, bus.G_in, bus.cin};
  assign {s1_p, s1_gp, s1_gg, s1_cin} = s1_q;

  prefix_pipe_reg #(.DW(S1_DW)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .adv     (s1_adv),
    .valid_d (bus.in_valid),
    .data_d  (s1_d),
    .valid_q (s1_valid),
    .data_q  (s1_q)
  );

  always_comb begin
    gp_ext = '0;
    gg_ext = '0;
    gp_ext[WIDTH:1] = s1_gp;
    gg_ext[WIDTH:1] = s1_gg;
    c_full = carry_from_prefix(gg_ext, gp_ext, s1_cin);
    c      = c_full[WIDTH:0];
    sum_d  = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      sum_d[i] = s1_p[i] ^ c[i-1];
    end
  end

  // Carries above WIDTH are always zero here; fold them so nothing is left dangling.
  assign c_unused = ^c_full;

`ifdef PREFIX_SUM_OVF_EN
  assign s2_d = {sum_d, c[WIDTH], c[WIDTH] ^ c[WIDTH-1]};
`else
  assign s2_d = {sum_d, c[WIDTH]};
`endif

  prefix_pipe_reg #(.DW(S2_DW)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .adv     (s2_adv),
    .valid_d (s1_valid),
    .data_d  (s2_d),
    .valid_q (s2_valid),
    .data_q  (s2_q)
  );

  assign bus.out_valid = s2_valid;
`ifdef PREFIX_SUM_OVF_EN
  assign {bus.sum, bus.cout, bus.ovf} = s2_q;
`else
  assign {bus.sum, bus.cout} = s2_q;
`endif

endmodule
